osd_num_display: RTL and testbench

OSD_NUM_DISPLAY -- requirements
Module: osd_num_display

---
 rtl/osd_num_display_pkg.sv | 43 ++++
 rtl/osd_seg_glyph.sv | 58 +++++
 rtl/osd_num_display.sv | 83 ++++++++
 tb/tb_osd_num_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/osd_num_display_pkg.sv
// Shared definitions for the on-screen numeric overlay: segment bit
// positions, digit-to-segment table, stroke geometry and the blank code.
package osd_num_display_pkg;

    // Bit index of each segment inside a 7-bit segment mask.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Stroke thickness of every segment, in pixels.
    localparam int STROKE_W = 2;

    // Fixed glyph cell geometry.
    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 32;

    // Digit code that draws nothing; also the value held after reset.
    localparam logic [3:0] NUM_BLANK = 4'd10;

    // Map a digit code to its lit-segment mask (bit SEG_x set = segment on).
    function automatic logic [6:0] digit_segs(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'b011_1111; // abcdef
            4'd1:    segs = 7'b000_0110; // bc
            4'd2:    segs = 7'b101_1011; // abdeg
            4'd3:    segs = 7'b100_1111; // abcdg
            4'd4:    segs = 7'b110_0110; // bcfg
            4'd5:    segs = 7'b110_1101; // acdfg
            4'd6:    segs = 7'b111_1101; // acdefg
            4'd7:    segs = 7'b000_0111; // abc
            4'd8:    segs = 7'b111_1111; // abcdefg
            4'd9:    segs = 7'b110_1111; // abcdfg
            default: segs = 7'b000_0000; // 10-15 blank
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/osd_seg_glyph.sv
// Combinational 7-segment glyph rasteriser for a fixed 16x32 cell.
// Given a digit and a (row, col) inside the cell, reports whether that
// pixel belongs to a lit segment.
module osd_seg_glyph
    import osd_num_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [4:0] row,
    input  logic [3:0] col,
    output logic       lit
);

    // Column bands: left stroke, right stroke, and the span between them.
    localparam logic [3:0] COL_L_END   = 4'(STROKE_W);
    localparam logic [3:0] COL_R_START = 4'(GLYPH_W - STROKE_W);
    // Row bands: top, middle and bottom strokes plus the two vertical spans.
    localparam logic [4:0] ROW_T_END   = 5'(STROKE_W);
    localparam logic [4:0] ROW_M_START = 5'((GLYPH_H - STROKE_W) / 2);
    localparam logic [4:0] ROW_M_END   = 5'((GLYPH_H + STROKE_W) / 2);
    localparam logic [4:0] ROW_B_START = 5'(GLYPH_H - STROKE_W);

    logic       col_left_s;
    logic       col_right_s;
    logic       col_mid_s;
    logic       row_top_s;
    logic       row_mid_s;
    logic       row_bot_s;
    logic       row_upper_s;
    logic       row_lower_s;
    logic [6:0] seg_area_s;
    logic [6:0] seg_on_s;

    // Classify the pixel into stroke bands and test it against the digit's segments.
    always_comb begin
        col_left_s  = (col < COL_L_END);
        col_right_s = (col >= COL_R_START);
        col_mid_s   = !col_left_s && !col_right_s;
        row_top_s   = (row < ROW_T_END);
        row_mid_s   = (row >= ROW_M_START) && (row < ROW_M_END);
        row_bot_s   = (row >= ROW_B_START);
        // Vertical strokes leave the corner and middle-row pixels unlit.
        row_upper_s = !row_top_s && (row < ROW_M_START);
        row_lower_s = (row >= ROW_M_END) && !row_bot_s;

        seg_area_s        = 7'b000_0000;
        seg_area_s[SEG_A] = row_top_s   && col_mid_s;
        seg_area_s[SEG_B] = row_upper_s && col_right_s;
        seg_area_s[SEG_C] = row_lower_s && col_right_s;
        seg_area_s[SEG_D] = row_bot_s   && col_mid_s;
        seg_area_s[SEG_E] = row_lower_s && col_left_s;
        seg_area_s[SEG_F] = row_upper_s && col_left_s;
        seg_area_s[SEG_G] = row_mid_s   && col_mid_s;

        seg_on_s = digit_segs(digit);
        lit      = |(seg_area_s & seg_on_s);
    end

endmodule

// File: rtl/osd_num_display.sv
// Single-digit on-screen display: draws a 16x32 seven-segment glyph at a
// fixed position in the active picture. The digit is sampled once per frame
// on the rising edge of pos_vs so the glyph never tears mid-frame.
module osd_num_display
    import osd_num_display_pkg::*;
#(
    parameter int OSD_WIDTH  = 16,
    parameter int OSD_HEIGHT = 32,
    parameter int OSD_X      = 16,
    parameter int OSD_Y      = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  num,
    input  logic [12:0] pos_x,
    input  logic [12:0] pos_y,
    input  logic        pos_de,
    input  logic        pos_vs,
    output logic        pos_en
);

    // Box bounds held one bit wider than the coordinates so the upper bound
    // cannot wrap when the box sits at the far edge of the 13-bit range.
    localparam logic [13:0] X_LO = 14'(OSD_X);
    localparam logic [13:0] X_HI = 14'(OSD_X + OSD_WIDTH);
    localparam logic [13:0] Y_LO = 14'(OSD_Y);
    localparam logic [13:0] Y_HI = 14'(OSD_Y + OSD_HEIGHT);
    // Only the low bits of the offset matter inside the box, so subtract
    // in the cell's own width.
    localparam logic [3:0]  X_LO_LSB = 4'(OSD_X);
    localparam logic [4:0]  Y_LO_LSB = 5'(OSD_Y);

    logic       vs_d_r;
    logic [3:0] num_lat_r;
    logic       pos_en_r;

    logic       vs_rise_s;
    logic       hit_s;
    logic [3:0] col_s;
    logic [4:0] row_s;
    logic       lit_s;

    // Frame-start detection, box hit test and in-cell coordinates.
    always_comb begin
        vs_rise_s = pos_vs && !vs_d_r;
        if (({1'b0, pos_x} >= X_LO) && ({1'b0, pos_x} < X_HI) &&
            ({1'b0, pos_y} >= Y_LO) && ({1'b0, pos_y} < Y_HI)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        col_s = pos_x[3:0] - X_LO_LSB;
        row_s = pos_y[4:0] - Y_LO_LSB;
    end

    osd_seg_glyph u_glyph (
        .digit (num_lat_r),
        .row   (row_s),
        .col   (col_s),
        .lit   (lit_s)
    );

    // Frame-synchronous digit latch and registered overlay enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_d_r    <= 1'b0;
            num_lat_r <= NUM_BLANK;
            pos_en_r  <= 1'b0;
        end else begin
            vs_d_r <= pos_vs;
            // The pixel sharing the sync edge still uses the old digit.
            if (vs_rise_s) begin
                num_lat_r <= num;
            end else begin
                num_lat_r <= num_lat_r;
            end
            pos_en_r <= pos_de && hit_s && lit_s;
        end
    end

    assign pos_en = pos_en_r;

endmodule

// File: tb/tb_osd_num_display.sv
// Self-checking bench for osd_num_display: a per-cycle reference model plus
// directed pixel probes with hand-derived expectations.
module tb_osd_num_display;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic [3:0]  num    = 4'd0;
    logic [12:0] pos_x  = 13'd0;
    logic [12:0] pos_y  = 13'd0;
    logic        pos_de = 1'b0;
    logic        pos_vs = 1'b0;
    logic        pos_en;

    osd_num_display #(
        .OSD_WIDTH  (16),
        .OSD_HEIGHT (32),
        .OSD_X      (16),
        .OSD_Y      (16)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .num    (num),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .pos_de (pos_de),
        .pos_vs (pos_vs),
        .pos_en (pos_en)
    );

    always #5 clk = ~clk;

    // Segment lists per digit, written exactly as the glyph table reads.
    string seg_str [0:9] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                             "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    // Reference: is screen pixel (x,y) lit for digit d when de is high?
    function automatic logic model_pix(input int d, input logic de,
                                       input int x, input int y);
        int    c;
        int    r;
        string s;
        c = x - 16;
        r = y - 16;
        if (!de || c < 0 || c > 15 || r < 0 || r > 31 || d > 9) return 1'b0;
        s = seg_str[d];
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a": if (r <= 1 && c >= 2 && c <= 13)                return 1'b1;
                "b": if (c >= 14 && r >= 2 && r <= 14)               return 1'b1;
                "c": if (c >= 14 && r >= 17 && r <= 29)              return 1'b1;
                "d": if (r >= 30 && c >= 2 && c <= 13)               return 1'b1;
                "e": if (c <= 1 && r >= 17 && r <= 29)               return 1'b1;
                "f": if (c <= 1 && r >= 2 && r <= 14)                return 1'b1;
                "g": if (r >= 15 && r <= 16 && c >= 2 && c <= 13)    return 1'b1;
                default: ;
            endcase
        end
        return 1'b0;
    endfunction

    // Model state: the digit shown this frame, previous sync, expected output.
    int   m_lat;
    logic m_vs;
    logic m_en;

    // Advance the reference model each clock.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lat <= 10;
            m_vs  <= 1'b0;
            m_en  <= 1'b0;
        end else begin
            m_en <= model_pix(m_lat, pos_de, int'(pos_x), int'(pos_y));
            m_vs <= pos_vs;
            if (pos_vs && !m_vs) m_lat <= int'(num);
        end
    end

    // Directed probe requests handed to the compare process.
    int    lit_seq  = 0;
    int    lit_done = 0;
    logic  lit_exp  = 1'b0;
    string lit_name = "";

    int n_checks = 0;
    int n_errors = 0;

    // Compare DUT against the model every cycle, plus any pending probe.
    always @(negedge clk) begin
        n_checks = n_checks + 1;
        if (pos_en !== m_en) begin
            n_errors = n_errors + 1;
            $display("FAIL model t=%0t x=%0d y=%0d: pos_en=%b expected=%b",
                     $time, pos_x, pos_y, pos_en, m_en);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            n_checks = n_checks + 1;
            if (pos_en !== lit_exp) begin
                n_errors = n_errors + 1;
                $display("FAIL %s: pos_en=%b expected=%b", lit_name, pos_en, lit_exp);
            end
        end
    end

    // Apply one pixel's inputs and let the clock take them.
    task automatic step(input int x, input int y, input logic de, input logic vs);
        pos_x  = 13'(x);
        pos_y  = 13'(y);
        pos_de = de;
        pos_vs = vs;
        @(posedge clk);
        #1;
    endtask

    // Queue a hand-computed expectation for the output now on pos_en.
    task automatic probe(input string name, input logic exp);
        lit_name = name;
        lit_exp  = exp;
        lit_seq  = lit_seq + 1;
        @(negedge clk);
        #1;
    endtask

    task automatic frame_sync(input int d);
        num = 4'(d);
        step(0, 0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        probe("reset_en", 1'b0);
        rstn = 1'b1;

        // Nothing lit before the first frame sync, even with a digit applied.
        num = 4'd8;
        step(18, 16, 1'b1, 1'b0);
        probe("blank_before_vs", 1'b0);

        // Digit 8, line 16: only segment a (x=18..29).
        frame_sync(8);
        for (int x = 0; x <= 40; x++) begin
            step(x, 16, 1'b1, 1'b0);
            probe("sweep8_y16", (x >= 18 && x <= 29) ? 1'b1 : 1'b0);
        end

        // Digit 1, line 20: right stroke only.
        frame_sync(1);
        for (int x = 0; x <= 40; x++) begin
            step(x, 20, 1'b1, 1'b0);
            probe("sweep1_y20", (x == 30 || x == 31) ? 1'b1 : 1'b0);
        end

        // Digit 0, line 20: both vertical strokes.
        frame_sync(0);
        for (int x = 0; x <= 40; x++) begin
            step(x, 20, 1'b1, 1'b0);
            probe("sweep0_y20", (x == 16 || x == 17 || x == 30 || x == 31) ? 1'b1 : 1'b0);
        end

        // Corner is dark, middle bar is lit, bottom bar is lit.
        frame_sync(8);
        step(16, 16, 1'b1, 1'b0); probe("corner8", 1'b0);
        step(18, 31, 1'b1, 1'b0); probe("seg_g8", 1'b1);
        step(29, 47, 1'b1, 1'b0); probe("seg_d8", 1'b1);
        step(31, 47, 1'b1, 1'b0); probe("corner8_br", 1'b0);
        step(18, 16, 1'b0, 1'b0); probe("de_low", 1'b0);

        // Digit change without sync is invisible until the next frame.
        num = 4'd1;
        step(18, 16, 1'b1, 1'b0); probe("hold8_a", 1'b1);
        // Sync edge coinciding with an active pixel still shows the old digit.
        step(18, 16, 1'b1, 1'b1); probe("vs_same_cycle", 1'b1);
        step(18, 16, 1'b1, 1'b1); probe("new1_a", 1'b0);
        step(30, 20, 1'b1, 1'b0); probe("new1_b", 1'b1);

        // Blank code: nothing anywhere in the box.
        frame_sync(12);
        for (int y = 14; y <= 49; y += 5) begin
            for (int x = 14; x <= 33; x++) step(x, y, 1'b1, 1'b0);
        end
        step(18, 16, 1'b1, 1'b0); probe("blank12", 1'b0);

        // Model-checked raster of every digit code over the box and a margin.
        for (int d = 0; d <= 15; d++) begin
            frame_sync(d);
            for (int y = 14; y <= 49; y++) begin
                for (int x = 14; x <= 33; x++) step(x, y, 1'b1, 1'b0);
            end
        end

        // Reset mid-box blanks at once and stays blank until a sync.
        frame_sync(8);
        step(20, 16, 1'b1, 1'b0);
        probe("pre_reset_lit", 1'b1);
        rstn = 1'b0;
        #1;
        probe("reset_immediate", 1'b0);
        step(20, 16, 1'b1, 1'b0);
        rstn = 1'b1;
        step(20, 16, 1'b1, 1'b0); probe("post_reset_blank", 1'b0);
        step(18, 31, 1'b1, 1'b0); probe("post_reset_blank_g", 1'b0);
        frame_sync(8);
        step(20, 16, 1'b1, 1'b0); probe("post_reset_relatch", 1'b1);

        step(0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
